// File: rtl/bs_pkg.sv
// Shared bus definitions: header layout, ID width and helpers used by the
// driver endpoints, the bus wrapper and the arbiter.
package bs_pkg;

    localparam int              ID_W         = 8;
    localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;
    localparam int              WORD_MAX     = 64;
    // header occupies [bits-HDR_MSB_OFS : bits-HDR_LSB_OFS]
    localparam int              HDR_MSB_OFS  = 1;
    localparam int              HDR_LSB_OFS  = ID_W;

    function automatic logic [ID_W-1:0] hdr_id(input logic [WORD_MAX-1:0] word,
                                               input int                  bits);
        return word[bits-HDR_LSB_OFS +: ID_W];
    endfunction

    function automatic logic hdr_hit(input logic [ID_W-1:0] hdr,
                                     input logic [ID_W-1:0] id,
                                     input logic [ID_W-1:0] bcast);
        return (hdr == id) || (hdr == bcast);
    endfunction

endpackage

// File: rtl/bs_drvr_fifo_intf_if.sv
// Bundle of bus-side and agent-side handshake signals for one driver endpoint.
interface bs_drvr_fifo_intf_if #(
    parameter int bits  = 32,
    parameter int depth = 16
);
    logic                     tx_valid;
    logic                     tx_ready;
    logic [bits-1:0]          tx_data;
    logic                     pndng;
    logic                     pop;
    logic [bits-1:0]          D_pop;
    logic                     push;
    logic [bits-1:0]          D_push;
    logic                     rx_valid;
    logic                     rx_ready;
    logic [bits-1:0]          rx_data;
    logic [$clog2(depth):0]   tx_count;
    logic [$clog2(depth):0]   rx_count;
    logic [2:0]               err_flags;

    modport slave (
        input  tx_valid, tx_data, pop, push, D_push, rx_ready,
        output tx_ready, pndng, D_pop, rx_valid, rx_data, tx_count, rx_count, err_flags
    );

    modport master (
        output tx_valid, tx_data, pop, push, D_push, rx_ready,
        input  tx_ready, pndng, D_pop, rx_valid, rx_data, tx_count, rx_count, err_flags
    );
endinterface

// File: rtl/bs_sync_fifo.sv
// Show-ahead synchronous FIFO; callers qualify wr_en/rd_en against full/empty.
module bs_sync_fifo #(
    parameter int bits  = 32,
    parameter int depth = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [bits-1:0]        wr_data,
    input  logic                   rd_en,
    output logic [bits-1:0]        rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(depth):0] count
);
    localparam int AW = $clog2(depth);
    localparam int PW = AW + 1;

    logic [bits-1:0] mem_q [depth];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(wr_en);
        rd_ptr_d = rd_ptr_q + PW'(rd_en);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    // extra pointer MSB distinguishes full from empty when the indices match
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/bs_drvr_fifo_intf.sv
// Driver-side bus endpoint: TX FIFO drained by the bus, RX FIFO filled by the
// bus with destination-ID filtering, plus sticky error flags.
module bs_drvr_fifo_intf
    import bs_pkg::*;
#(
    parameter int              bits      = 32,
    parameter logic [ID_W-1:0] id        = 8'h00,
    parameter logic [ID_W-1:0] broadcast = BROADCAST_ID,
    parameter int              depth     = 16,
    parameter bit              filter_en = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    bs_drvr_fifo_intf_if.slave   bus_io
);
    logic tx_full, tx_empty, tx_wr, tx_rd;
    logic rx_full, rx_empty, rx_wr, rx_rd;
    logic id_hit;
    logic [2:0] err_q, err_d;

    // tx_ready depends only on occupancy so the bus pop never loops back into it
    assign tx_wr  = bus_io.tx_valid & ~tx_full;
    assign tx_rd  = bus_io.pop & ~tx_empty;
    assign id_hit = ~filter_en | hdr_hit(hdr_id(WORD_MAX'(bus_io.D_push), bits), id, broadcast);
    assign rx_rd  = bus_io.rx_ready & ~rx_empty;
    // a same-cycle read frees a slot, so a push into a full FIFO still lands
    assign rx_wr  = bus_io.push & id_hit & (~rx_full | rx_rd);

    always_comb begin
        err_d    = err_q;
        err_d[0] = err_q[0] | (bus_io.pop & tx_empty);
        err_d[1] = err_q[1] | (bus_io.push & id_hit & rx_full & ~rx_rd);
        err_d[2] = err_q[2] | (bus_io.push & ~id_hit);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= '0;
        else       err_q <= err_d;
    end

    bs_sync_fifo #(.bits(bits), .depth(depth)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tx_wr),
        .wr_data (bus_io.tx_data),
        .rd_en   (tx_rd),
        .rd_data (bus_io.D_pop),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (bus_io.tx_count)
    );

    bs_sync_fifo #(.bits(bits), .depth(depth)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rx_wr),
        .wr_data (bus_io.D_push),
        .rd_en   (rx_rd),
        .rd_data (bus_io.rx_data),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (bus_io.rx_count)
    );

    assign bus_io.tx_ready  = ~tx_full;
    assign bus_io.pndng     = ~tx_empty;
    assign bus_io.rx_valid  = ~rx_empty;
    assign bus_io.err_flags = err_q;

endmodule

// File: tb/tb_bs_drvr_fifo_intf.sv
// Directed and random stimulus for bs_drvr_fifo_intf against a queue-based model.
module tb_bs_drvr_fifo_intf;
    localparam int         BITS  = 32;
    localparam int         DEPTH = 16;
    localparam logic [7:0] MY_ID = 8'h03;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    logic [BITS-1:0] tx_q[$];
    logic [BITS-1:0] rx_q[$];
    logic [2:0]      err_m;

    always #5 clk = ~clk;

    bs_drvr_fifo_intf_if #(.bits(BITS), .depth(DEPTH)) bus_if ();

    bs_drvr_fifo_intf #(
        .bits(BITS), .id(MY_ID), .broadcast(8'hFF), .depth(DEPTH), .filter_en(1'b1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus_if)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("pndng",    64'(bus_if.pndng),     64'(tx_q.size() != 0));
        chk("tx_ready", 64'(bus_if.tx_ready),  64'(tx_q.size() < DEPTH));
        chk("tx_count", 64'(bus_if.tx_count),  64'(tx_q.size()));
        chk("rx_valid", 64'(bus_if.rx_valid),  64'(rx_q.size() != 0));
        chk("rx_count", 64'(bus_if.rx_count),  64'(rx_q.size()));
        chk("err",      64'(bus_if.err_flags), 64'(err_m));
        if (tx_q.size() != 0) chk("D_pop",   64'(bus_if.D_pop),   64'(tx_q[0]));
        if (rx_q.size() != 0) chk("rx_data", 64'(bus_if.rx_data), 64'(rx_q[0]));
    endtask

    // one clock: check state at the falling edge, apply inputs, advance the model
    task automatic cycle(input logic tv, input logic [BITS-1:0] td, input logic pp,
                         input logic ps, input logic [BITS-1:0] dp, input logic rr);
        logic hit, rd;
        @(negedge clk);
        check_outputs();
        bus_if.tx_valid = tv;
        bus_if.tx_data  = td;
        bus_if.pop      = pp;
        bus_if.push     = ps;
        bus_if.D_push   = dp;
        bus_if.rx_ready = rr;

        if (pp && tx_q.size() == 0) err_m[0] = 1'b1;
        if (tv && tx_q.size() < DEPTH) begin
            if (pp && tx_q.size() != 0) void'(tx_q.pop_front());
            tx_q.push_back(td);
        end else if (pp && tx_q.size() != 0) begin
            void'(tx_q.pop_front());
        end

        rd = rr && rx_q.size() != 0;
        if (rd) void'(rx_q.pop_front());
        hit = (dp[BITS-1 -: 8] == MY_ID) || (dp[BITS-1 -: 8] == 8'hFF);
        if (ps) begin
            if (!hit)                    err_m[2] = 1'b1;
            else if (rx_q.size() < DEPTH) rx_q.push_back(dp);
            else                         err_m[1] = 1'b1;
        end
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_pndng",    64'(bus_if.pndng),     64'd0);
        chk("rst_tx_ready", 64'(bus_if.tx_ready),  64'd1);
        chk("rst_rx_valid", 64'(bus_if.rx_valid),  64'd0);
        chk("rst_tx_count", 64'(bus_if.tx_count),  64'd0);
        chk("rst_rx_count", 64'(bus_if.rx_count),  64'd0);
        chk("rst_err",      64'(bus_if.err_flags), 64'd0);
        tx_q.delete();
        rx_q.delete();
        err_m = '0;
        bus_if.tx_valid = 1'b0;
        bus_if.pop      = 1'b0;
        bus_if.push     = 1'b0;
        bus_if.rx_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [BITS-1:0] w;
        logic [7:0]      hid;
        err_m           = '0;
        bus_if.tx_valid = 1'b0;
        bus_if.tx_data  = '0;
        bus_if.pop      = 1'b0;
        bus_if.push     = 1'b0;
        bus_if.D_push   = '0;
        bus_if.rx_ready = 1'b0;
        async_reset();

        // TX write three, then pop them out
        for (int i = 1; i <= 3; i++) cycle(1'b1, 32'h0100_0000 + i, 1'b0, 1'b0, '0, 1'b0);
        idle();
        chk("t1_count", 64'(bus_if.tx_count), 64'd3);
        chk("t1_dpop",  64'(bus_if.D_pop),    64'h0100_0001);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        idle();
        chk("t1_pndng", 64'(bus_if.pndng),     64'd0);
        chk("t1_err",   64'(bus_if.err_flags), 64'd0);

        // TX fill to full, then stream with pop every cycle
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h0200_0000 + i, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 32'h0200_0100, 1'b1, 1'b0, '0, 1'b0);
        chk("t2_full_ready", 64'(bus_if.tx_ready), 64'd0);
        for (int i = 1; i < 24; i++) cycle(1'b1, 32'h0200_0100 + i, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        idle();

        // RX ID filter
        cycle(1'b0, '0, 1'b0, 1'b1, 32'h03AB_CDEF, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 32'hFFAB_CDEF, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 32'h05AB_CDEF, 1'b0);
        idle();
        chk("t3_count", 64'(bus_if.rx_count),     64'd2);
        chk("t3_first", 64'(bus_if.rx_data),      64'h03AB_CDEF);
        chk("t3_drop",  64'(bus_if.err_flags[2]), 64'd1);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        idle();
        chk("t3_second", 64'(bus_if.rx_data), 64'hFFAB_CDEF);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        idle();

        // RX overflow, then full-with-read push after a reset
        for (int i = 0; i <= DEPTH; i++) cycle(1'b0, '0, 1'b0, 1'b1, 32'hFF00_0000 + i, 1'b0);
        idle();
        chk("t4_count", 64'(bus_if.rx_count),     64'd16);
        chk("t4_ovf",   64'(bus_if.err_flags[1]), 64'd1);
        async_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b0, 1'b1, 32'hFF10_0000 + i, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 32'hFF10_0010, 1'b1);
        idle();
        chk("t4b_count", 64'(bus_if.rx_count),     64'd16);
        chk("t4b_noovf", 64'(bus_if.err_flags[1]), 64'd0);
        chk("t4b_head",  64'(bus_if.rx_data),      64'hFF10_0001);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

        // underflow, then reset with TX holding 5 words
        cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        idle();
        chk("t5_under", 64'(bus_if.err_flags[0]), 64'd1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0500_0000 + i, 1'b0, 1'b0, '0, 1'b0);
        idle();
        async_reset();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0:       hid = MY_ID;
                1:       hid = 8'hFF;
                2:       hid = 8'($urandom);
                default: hid = MY_ID;
            endcase
            w = {hid, 24'($urandom)};
            cycle(1'($urandom_range(0, 3) != 0), 32'($urandom), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 2) != 0), w, 1'($urandom_range(0, 2) == 0));
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/bs_drvr_fifo_intf.md
Name: bs_drvr_fifo_intf

Overview:
Driver-side endpoint of the parallel bus generator/arbiter. It holds one TX FIFO that the bus drains through the pndng/pop/D_pop handshake, and one RX FIFO that the bus fills through the push/D_push handshake. It also presents a valid/ready stream interface to the local agent, such as the matrix-multiplier datapath or the DMA shim. One instance sits on each drvr_N_bus_0 port set of the bus.

Parameters:
bits, 32, word width; header field is bits [bits-1:bits-8] (destination ID)
id, 0, this driver's 8-bit ID; must differ from broadcast
broadcast, 8'hFF, destination ID accepted by every driver
depth, 16, entries per FIFO; power of 2, ≥2
filter_en, 1, 1 = RX drops words whose ID is neither id nor broadcast

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
tx_valid  in  1  local agent offers tx_data
tx_ready  out  1  TX FIFO not full
tx_data  in  bits  word to send; header already holds destination ID
pndng  out  1  to bus: TX FIFO non-empty
pop  in  1  from bus: consume TX head this cycle
D_pop  out  bits  to bus: TX head word (show-ahead)
push  in  1  from bus: D_push valid this cycle
D_push  in  bits  from bus: delivered word
rx_valid  out  1  RX FIFO non-empty
rx_ready  in  1  local agent consumes rx_data
rx_data  out  bits  RX head word (show-ahead)
tx_count  out  $clog2(depth)+1  TX occupancy
rx_count  out  $clog2(depth)+1  RX occupancy
err_flags  out  3  sticky: [0] TX underflow (pop while empty), [1] RX overflow (push while full), [2] RX misroute drop

Behaviour:
- Reset (async assert, released synchronously to clk): pointers, counts and err_flags are 0. Outputs go to pndng=0, tx_ready=1, rx_valid=0, tx_count=0, rx_count=0. D_pop and rx_data are don't-care while the matching FIFO is empty. Reset mid-transfer discards all contents; nothing is replayed.
- TX write: tx_valid&tx_ready writes tx_data at the tail.
  - Latency to pndng=1 is 1 cycle.
  - D_pop equals the written word in that same cycle when the FIFO was empty.
- TX pop: pop&pndng advances the head. The next entry appears on D_pop the following cycle.
  - pop while empty: no state change, err_flags[0] set.
- TX simultaneous write and pop:
  - Both take effect; count unchanged.
  - When full, tx_ready=0, so the write is blocked even if pop is high. tx_ready is never a combinational function of pop.
- RX push, accepted: the word is written at the tail when push=1 and the ID check passes (D_push[bits-1:bits-8] equals id or broadcast, or filter_en=0).
  - rx_valid rises 1 cycle later.
- RX push, failed ID check: the word is dropped and err_flags[2] set.
- RX push while full: the word is dropped, err_flags[1] set. There is no backpressure to the bus; the bus push is fire-and-forget.
- RX read: rx_valid&rx_ready advances the head. rx_ready while empty is ignored and is not an error.
- RX simultaneous push and read when full: the read frees the slot in the same cycle, so the push is accepted and there is no overflow.
- Pointers are $clog2(depth)+1 bits and wrap naturally.
  - full: MSBs differ and LSBs equal.
  - empty: pointers equal.
- Counts saturate structurally at depth and never exceed it.
- err_flags clear only on reset.
- Data is never modified; the header passes through unchanged.

Decomposition:
- Package bs_pkg holds:
  - ID_W=8 and BROADCAST_ID=8'hFF
  - functions hdr_id(word) and hdr_hit(word, id) and the header bit-position constants, shared with the bus wrapper and the arbiter.
- Sub-module bs_sync_fifo (params bits, depth; ports wr_en, wr_data, rd_en, rd_data, full, empty, count) is instantiated twice. The ID filter, error logic and handshakes live in the top.

Test Plan:
1. Reset, then write 3 words 0x01000001..0x01000003 with pop=0 -> pndng=1 one cycle after the first write, tx_count=3, D_pop=0x01000001. Pop three times -> D_pop walks 0x..02, 0x..03, then pndng=0 and err_flags=0.
2. Fill TX with 16 words, then hold tx_valid=1 with pop=1 every cycle -> tx_ready=0 on the first full cycle; afterwards exactly one write per pop; no data lost or reordered.
3. id=3, filter_en=1. Push 0x03ABCDEF, 0xFFABCDEF, 0x05ABCDEF -> rx_count=2, rx_data order 0x03ABCDEF then 0xFFABCDEF, err_flags[2]=1.
4. Push 17 words (ID=broadcast) with rx_ready=0 -> rx_count=16, err_flags[1]=1, 17th word absent. Repeat with rx_ready=1 in the 17th cycle -> no overflow.
5. pop=1 while empty -> err_flags[0]=1, pointers unchanged. Then assert reset mid-stream with TX holding 5 words -> all counts 0, pndng=0, err_flags=0 immediately without a clock edge.
